// File: rtl/d_ff_sync_reset.sv
// Positive-edge D register with synchronous, active-high reset.
// q is taken straight from the flop, so there is no combinational path from d or reset.
module d_ff_sync_reset #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Reset wins over d whenever it is sampled high
   always_comb begin
      q_d = d;
      if (reset) begin
         q_d = RESET_VALUE;
      end
   end

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: tb/tb_d_ff_sync_reset.sv
// Directed bench for d_ff_sync_reset: a 1-bit default instance and an 8-bit instance with reset value A5.
// A spec-level model is checked on every falling edge, plus hand-computed literal checks.
module tb_d_ff_sync_reset;

   logic       clk = 1'b0;
   logic       rst;
   logic       d1;
   logic [7:0] d8;
   logic       q1;
   logic [7:0] q8;

   int total = 0;
   int bad   = 0;

   logic       m1;
   logic [7:0] m8;
   logic       mvld = 1'b0;

   d_ff_sync_reset u_dut1 (
      .clk   (clk),
      .reset (rst),
      .d     (d1),
      .q     (q1)
   );

   d_ff_sync_reset #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk   (clk),
      .reset (rst),
      .d     (d8),
      .q     (q8)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: after each rising edge the stored word is the reset value if reset was high, else d
   always @(posedge clk) begin
      m1 <= rst ? 1'b0 : d1;
      m8 <= rst ? 8'hA5 : d8;
      if (rst) mvld <= 1'b1;
   end

   always @(negedge clk) begin
      if (mvld) begin
         chk("model_q1", {7'd0, q1}, {7'd0, m1});
         chk("model_q8", q8, m8);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      d1  = 1'b1;
      d8  = 8'hFF;

      // reset priority over d for two edges
      @(negedge clk);
      chk("rst_q1_e1", {7'd0, q1}, 8'h00);
      chk("rst_q8_e1", q8, 8'hA5);
      @(negedge clk);
      chk("rst_q1_e2", {7'd0, q1}, 8'h00);
      chk("rst_q8_e2", q8, 8'hA5);

      // plain capture, one-cycle latency
      rst = 1'b0; d1 = 1'b1; d8 = 8'h3C;
      @(negedge clk);
      chk("cap_q1_1", {7'd0, q1}, 8'h01);
      chk("cap_q8_3c", q8, 8'h3C);
      d1 = 1'b0; d8 = 8'hC3;
      @(negedge clk);
      chk("cap_q1_0", {7'd0, q1}, 8'h00);
      chk("cap_q8_c3", q8, 8'hC3);
      d1 = 1'b1; d8 = 8'h00;
      @(negedge clk);
      chk("cap_q1_1b", {7'd0, q1}, 8'h01);
      chk("cap_q8_00", q8, 8'h00);

      // reset pulse between edges must not touch q
      d8 = 8'h5A;
      rst = 1'b1;
      #3;
      chk("mid_pulse_q1", {7'd0, q1}, 8'h01);
      chk("mid_pulse_q8", q8, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("pulse_q1", {7'd0, q1}, 8'h01);
      chk("pulse_q8", q8, 8'h5A);

      // reset mid-operation held two edges, then release
      rst = 1'b1; d1 = 1'b1; d8 = 8'h77;
      @(negedge clk);
      chk("mid_rst_q1_e1", {7'd0, q1}, 8'h00);
      chk("mid_rst_q8_e1", q8, 8'hA5);
      @(negedge clk);
      chk("mid_rst_q1_e2", {7'd0, q1}, 8'h00);
      chk("mid_rst_q8_e2", q8, 8'hA5);
      rst = 1'b0;
      @(negedge clk);
      chk("release_q1", {7'd0, q1}, 8'h01);
      chk("release_q8", q8, 8'h77);

      // glitches on d between edges; only the value at the edge counts
      d1 = 1'b1; d8 = 8'h11;
      #2 d1 = 1'b0; d8 = 8'h22;
      #2 chk("glitch_hold_q1", {7'd0, q1}, 8'h01);
      chk("glitch_hold_q8", q8, 8'h77);
      d1 = 1'b1; d8 = 8'h33;
      #2 d1 = 1'b0; d8 = 8'h96;
      @(negedge clk);
      chk("glitch_q1", {7'd0, q1}, 8'h00);
      chk("glitch_q8", q8, 8'h96);

      // a short run of alternating values
      for (int i = 0; i < 6; i++) begin
         d1 = i[0];
         d8 = 8'(8'h10 * i + 8'h01);
         @(negedge clk);
         chk("seq_q1", {7'd0, q1}, {7'd0, i[0]});
         chk("seq_q8", q8, 8'(8'h10 * i + 8'h01));
      end

      // stability check just after a rising edge
      @(posedge clk);
      #1;
      chk("post_edge_q8", q8, 8'h51);
      d8 = 8'hEE;
      #3;
      chk("post_edge_hold_q8", q8, 8'h51);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
